pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
Multi-channel PWM generator with one shared period counter, a runtime-programmable period, and per-channel duty and polarity. It supports edge-aligned (sawtooth) and center-aligned (triangle) modes. Period, duty and mode pass through shadow registers and take effect only at a period boundary, so outputs never glitch. It drives motor, LED and timing outputs and emits a period-sync pulse for downstream samplers.

Parameters:
CNT_W, 8, width of counter, period and each duty field
CH, 4, number of PWM channels

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  asynchronous reset, active-high
en_i  input  1  run enable; low holds counter idle
period_i  input  CNT_W  period value P
duty_i  input  CH*CNT_W  per-channel duty; channel k in bits [k*CNT_W +: CNT_W]
mode_i  input  1  0 = edge-aligned, 1 = center-aligned
load_i  input  1  one-cycle request to transfer period_i, duty_i and mode_i into the shadow registers
pol_i  input  CH  per-channel polarity; 1 = inverted output, applied immediately
pwm_o  output  CH  PWM outputs, registered
cnt_o  output  CNT_W  current counter value
dir_o  output  1  count direction; 0 = up, 1 = down (always 0 in edge mode)
sync_o  output  1  one-cycle pulse on the first cycle of each period
load_ack_o  output  1  one-cycle pulse in the cycle the new settings first take effect

Behaviour:
- Reset (asynchronous, any time): cnt_o=0, dir_o=0, pwm_o=0, sync_o=0, load_ack_o=0, pending=0.
  - Active registers on reset: period=2^CNT_W-1, all duties=0, mode=0.
- Load handling: load_i sets an internal pending flag.
  - While en_i=1, pending is applied at the boundary cycle. load_i asserted in the boundary cycle itself applies at that same boundary.
  - The values captured are period_i, duty_i and mode_i sampled in the applying cycle.
  - Applying a load clears pending. load_ack_o pulses together with the first cycle (cnt_o=0) of the period that uses the new values.
  - While en_i=0, pending is applied on the next clock edge and load_ack_o pulses on that edge.
- Edge mode counting: the counter goes 0,1,…,P, then wraps to 0. The period is P+1 cycles.
  - Boundary = cycle with cnt_o==P.
- Center mode counting: the counter goes up 0..P, then down P-1..1, then returns to 0. The period is 2P cycles.
  - dir_o=1 on the downward cycles.
  - Boundary = cycle with dir_o=1 and cnt_o==1.
  - P==0 or P==1: the counter stays at 0 / alternates 0,1; every cycle with cnt_o==0 starts a period.
- Channel compare: raw_k = (cnt < duty_k), unsigned, full CNT_W width. pwm_o[k] = raw_k XOR pol_i[k].
  - pwm_o is registered from the next counter value, so pwm_o is cycle-aligned with cnt_o.
  - duty_k=0 gives constant inactive level.
  - Edge mode: duty_k ≥ P+1 gives constant active level.
  - Center mode: duty_k > P gives constant active level.
- sync_o: high exactly in cycles where a new period starts (cnt_o==0, and for center mode dir_o=0), only while en_i=1.
- en_i low:
  - On the next edge, the counter goes to 0, dir_o to 0 and sync_o to 0.
  - pwm_o[k] = pol_i[k] (inactive level).
- en_i rising: the first enabled cycle has cnt_o=0 and sync_o=1, and starts a full period.
- Changing pol_i affects pwm_o on the next edge, with no boundary wait.
- Reset during operation discards pending loads and all active settings.

Test Plan:
- Reset with rst_i=1 mid-run, CNT_W=8, CH=4 -> immediately pwm_o=0, cnt_o=0, sync_o=0, load_ack_o=0. After release with en_i=0 -> pwm_o equals pol_i.
- Edge mode: P=7, duty0=3, duty1=0, duty2=8, duty3=5, pol=0; load then en_i=1 -> period 8 cycles, sync_o every 8 cycles. pwm_o[0]=1 for cnt 0..2; pwm_o[1] always 0; pwm_o[2] always 1; pwm_o[3]=1 for cnt 0..4.
- Center mode: P=4, duty0=2 -> cnt_o sequence 0,1,2,3,4,3,2,1 with dir_o 0,0,0,0,0,1,1,1. pwm_o[0] sequence 1,1,0,0,0,0,0,1, repeating every 8 cycles.
- Shadow update: running edge mode with P=7, duty0=3; pulse load_i with duty0=6 at cnt_o=2 -> current period keeps 3 high cycles. load_ack_o and sync_o pulse together at the next cnt_o=0; 6 high cycles thereafter.
- load_i in boundary cycle (cnt_o=7) with P=3 -> next cycle has cnt_o=0 and load_ack_o=1; new period is 4 cycles.
- Polarity and enable: pol_i[1]=1 with duty1=0 -> pwm_o[1] constant 1. Drop en_i mid-period -> next cycle cnt_o=0 and pwm_o=pol_i. Re-enable -> sync_o=1 on the first cycle.

Source files
------------

// File: rtl/pwm_multi_gen_if.sv
// rtl/pwm_multi_gen_if.sv - configuration and output bundle for the multi-channel PWM generator
interface pwm_multi_gen_if #(
  parameter int CNT_W = 8,
  parameter int CH    = 4
);
  logic                en_i;
  logic [CNT_W-1:0]    period_i;
  logic [CH*CNT_W-1:0] duty_i;
  logic                mode_i;
  logic                load_i;
  logic [CH-1:0]       pol_i;
  logic [CH-1:0]       pwm_o;
  logic [CNT_W-1:0]    cnt_o;
  logic                dir_o;
  logic                sync_o;
  logic                load_ack_o;

  modport master (
    output en_i, period_i, duty_i, mode_i, load_i, pol_i,
    input  pwm_o, cnt_o, dir_o, sync_o, load_ack_o
  );

  modport slave (
    input  en_i, period_i, duty_i, mode_i, load_i, pol_i,
    output pwm_o, cnt_o, dir_o, sync_o, load_ack_o
  );
endinterface

// File: rtl/pwm_multi_gen.sv
// rtl/pwm_multi_gen.sv - shared-counter PWM generator, edge/center aligned, shadowed period/duty/mode
module pwm_multi_gen #(
  parameter int CNT_W = 8,
  parameter int CH    = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  pwm_multi_gen_if.slave bus
);

  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                dir_q, dir_n;
  logic [CNT_W-1:0]    period_q, period_n;
  logic [CH*CNT_W-1:0] duty_q, duty_n;
  logic                mode_q, mode_n;
  logic                pending_q;
  logic                running_q;
  logic [CH-1:0]       pwm_q, pwm_n;
  logic                sync_q, sync_n;
  logic                ack_q;
  logic                boundary;
  logic                apply;

  // Last cycle of the current period, judged against the active settings.
  always_comb begin
    boundary = 1'b0;
    if (mode_q && (period_q >= CNT_W'(2)))
      boundary = dir_q && (cnt_q == CNT_W'(1));
    else
      boundary = (cnt_q == period_q);
  end

  // Disabled: a request lands on the very next edge; enabled: only at the period boundary.
  assign apply = (pending_q | bus.load_i) & (bus.en_i ? boundary : 1'b1);

  always_comb begin
    cnt_n    = '0;
    dir_n    = 1'b0;
    period_n = apply ? bus.period_i : period_q;
    duty_n   = apply ? bus.duty_i   : duty_q;
    mode_n   = apply ? bus.mode_i   : mode_q;
    if (bus.en_i && running_q && !boundary) begin
      if (!mode_q) begin
        cnt_n = cnt_q + CNT_W'(1);
      end else if (!dir_q && (cnt_q != period_q)) begin
        cnt_n = cnt_q + CNT_W'(1);
      end else begin
        cnt_n = cnt_q - CNT_W'(1);
        dir_n = 1'b1;
      end
    end
    sync_n = bus.en_i && (cnt_n == '0);
    pwm_n  = bus.pol_i;
    if (bus.en_i) begin
      for (int k = 0; k < CH; k++)
        pwm_n[k] = (cnt_n < duty_n[k*CNT_W +: CNT_W]) ^ bus.pol_i[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      period_q  <= '1;
      duty_q    <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      running_q <= 1'b0;
      pwm_q     <= '0;
      sync_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_n;
      dir_q     <= dir_n;
      period_q  <= period_n;
      duty_q    <= duty_n;
      mode_q    <= mode_n;
      pending_q <= apply ? 1'b0 : (pending_q | bus.load_i);
      running_q <= bus.en_i;
      pwm_q     <= pwm_n;
      sync_q    <= sync_n;
      ack_q     <= apply;
    end
  end

  assign bus.cnt_o      = cnt_q;
  assign bus.dir_o      = dir_q;
  assign bus.pwm_o      = pwm_q;
  assign bus.sync_o     = sync_q;
  assign bus.load_ack_o = ack_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb/tb_pwm_multi_gen.sv - table, directed and randomized checks of pwm_multi_gen against a period-phase model
module tb_pwm_multi_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_multi_gen_if #(.CNT_W(8), .CH(4)) bus_if ();

  pwm_multi_gen #(.CNT_W(8), .CH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    logic        en;
    logic        ld;
    logic        md;
    logic [7:0]  per;
    logic [31:0] duty;
    logic [3:0]  pol;
    logic [7:0]  e_cnt;
    logic        e_dir;
    logic [3:0]  e_pwm;
    logic        e_sync;
    logic        e_ack;
  } vec_t;

  vec_t tbl [20];

  // Model: position t within the period, period length from the active settings.
  logic [7:0]  m_per;
  logic [31:0] m_duty;
  logic        m_mode, m_pend, m_run;
  int          m_t;
  logic [7:0]  e_cnt;
  logic        e_dir, e_sync, e_ack;
  logic [3:0]  e_pwm;

  function automatic int per_len(logic [7:0] p, logic md);
    if (!md) return int'(p) + 1;
    if (p == 8'd0) return 1;
    return 2 * int'(p);
  endfunction

  task automatic model_reset();
    m_per = 8'hFF; m_duty = '0; m_mode = 1'b0; m_pend = 1'b0; m_run = 1'b0; m_t = 0;
    e_cnt = '0; e_dir = 1'b0; e_pwm = '0; e_sync = 1'b0; e_ack = 1'b0;
  endtask

  task automatic model_step();
    logic app;
    logic last;
    last = (m_t == per_len(m_per, m_mode) - 1);
    if (!bus_if.en_i) begin
      app = m_pend | bus_if.load_i;
      m_run = 1'b0;
      m_t = 0;
    end else begin
      app = (m_pend | bus_if.load_i) & last;
      if (!m_run || last) m_t = 0;
      else m_t = m_t + 1;
      m_run = 1'b1;
    end
    m_pend = app ? 1'b0 : (m_pend | bus_if.load_i);
    if (app) begin
      m_per = bus_if.period_i; m_duty = bus_if.duty_i; m_mode = bus_if.mode_i;
    end
    e_ack = app;
    if (!bus_if.en_i) begin
      e_cnt = '0; e_dir = 1'b0; e_sync = 1'b0; e_pwm = bus_if.pol_i;
    end else begin
      if (!m_mode || m_t <= int'(m_per)) begin
        e_cnt = 8'(m_t); e_dir = 1'b0;
      end else begin
        e_cnt = 8'(2 * int'(m_per) - m_t); e_dir = 1'b1;
      end
      e_sync = (m_t == 0);
      for (int k = 0; k < 4; k++)
        e_pwm[k] = (e_cnt < m_duty[k*8 +: 8]) ^ bus_if.pol_i[k];
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, bus_if.pwm_o, bus_if.cnt_o, bus_if.dir_o, bus_if.sync_o, bus_if.load_ack_o};
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model", outs(), {17'd0, e_pwm, e_cnt, e_dir, e_sync, e_ack});
  endtask

  task automatic wait_cnt(logic [7:0] v, string nm);
    int n = 0;
    while (bus_if.cnt_o !== v && n < 600) begin
      cyc();
      n++;
    end
    chk(nm, 32'(bus_if.cnt_o), 32'(v));
  endtask

  function automatic vec_t mk(logic en, logic ld, logic md, logic [7:0] per, logic [31:0] duty,
                              logic [7:0] c, logic d, logic [3:0] p, logic s, logic a);
    vec_t v;
    v.en = en; v.ld = ld; v.md = md; v.per = per; v.duty = duty; v.pol = 4'b0000;
    v.e_cnt = c; v.e_dir = d; v.e_pwm = p; v.e_sync = s; v.e_ack = a;
    return v;
  endfunction

  initial begin
    int hi, s, all1;
    tbl[0]  = mk(0, 1, 0, 8'd7, 32'h05080003, 8'd0, 0, 4'b0000, 0, 1);
    tbl[1]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd0, 0, 4'b1101, 1, 0);
    tbl[2]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd1, 0, 4'b1101, 0, 0);
    tbl[3]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd2, 0, 4'b1101, 0, 0);
    tbl[4]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd3, 0, 4'b1100, 0, 0);
    tbl[5]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd4, 0, 4'b1100, 0, 0);
    tbl[6]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd5, 0, 4'b0100, 0, 0);
    tbl[7]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd6, 0, 4'b0100, 0, 0);
    tbl[8]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd7, 0, 4'b0100, 0, 0);
    tbl[9]  = mk(1, 0, 0, 8'd7, 32'h05080003, 8'd0, 0, 4'b1101, 1, 0);
    tbl[10] = mk(0, 1, 1, 8'd4, 32'h00000002, 8'd0, 0, 4'b0000, 0, 1);
    tbl[11] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd0, 0, 4'b0001, 1, 0);
    tbl[12] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd1, 0, 4'b0001, 0, 0);
    tbl[13] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd2, 0, 4'b0000, 0, 0);
    tbl[14] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd3, 0, 4'b0000, 0, 0);
    tbl[15] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd4, 0, 4'b0000, 0, 0);
    tbl[16] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd3, 1, 4'b0000, 0, 0);
    tbl[17] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd2, 1, 4'b0000, 0, 0);
    tbl[18] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd1, 1, 4'b0001, 0, 0);
    tbl[19] = mk(1, 0, 1, 8'd4, 32'h00000002, 8'd0, 0, 4'b0001, 1, 0);

    rst = 1'b1;
    bus_if.en_i = 1'b0; bus_if.load_i = 1'b0; bus_if.mode_i = 1'b0;
    bus_if.period_i = '0; bus_if.duty_i = '0; bus_if.pol_i = '0;
    model_reset();
    #1;
    chk("reset_state", outs(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus_if.en_i = tbl[i].en; bus_if.load_i = tbl[i].ld; bus_if.mode_i = tbl[i].md;
      bus_if.period_i = tbl[i].per; bus_if.duty_i = tbl[i].duty; bus_if.pol_i = tbl[i].pol;
      cyc();
      chk($sformatf("tbl%0d", i), outs(),
          {17'd0, tbl[i].e_pwm, tbl[i].e_cnt, tbl[i].e_dir, tbl[i].e_sync, tbl[i].e_ack});
    end

    // Shadowed duty change mid-period
    bus_if.en_i = 1'b0; bus_if.load_i = 1'b1; bus_if.mode_i = 1'b0;
    bus_if.period_i = 8'd7; bus_if.duty_i = 32'h00000003;
    cyc();
    bus_if.load_i = 1'b0; bus_if.en_i = 1'b1;
    cyc();
    wait_cnt(8'd2, "wait_cnt2");
    bus_if.load_i = 1'b1; bus_if.duty_i = 32'h00000006;
    cyc();
    bus_if.load_i = 1'b0;
    hi = 0; s = 0;
    while (bus_if.cnt_o !== 8'd0 && s < 16) begin
      hi += int'(bus_if.pwm_o[0]);
      cyc();
      s++;
    end
    chk("old_duty_tail", 32'(hi), 32'd0);
    chk("ack_with_sync", {30'd0, bus_if.load_ack_o, bus_if.sync_o}, 32'd3);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(bus_if.pwm_o[0]);
      cyc();
    end
    chk("new_duty_high", 32'(hi), 32'd6);

    // Load requested in the boundary cycle itself
    wait_cnt(8'd7, "wait_cnt7");
    bus_if.load_i = 1'b1; bus_if.period_i = 8'd3;
    cyc();
    bus_if.load_i = 1'b0;
    chk("bnd_load_ack", {23'd0, bus_if.cnt_o, bus_if.load_ack_o}, 32'd1);
    s = 0;
    for (int i = 0; i < 8; i++) begin
      s += int'(bus_if.sync_o);
      cyc();
    end
    chk("p3_sync_count", 32'(s), 32'd2);

    // Polarity applied immediately, enable drop and restart
    bus_if.pol_i = 4'b0010;
    all1 = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      all1 &= int'(bus_if.pwm_o[1]);
    end
    chk("pol_const", 32'(all1), 32'd1);
    wait_cnt(8'd2, "wait_cnt2b");
    bus_if.en_i = 1'b0;
    cyc();
    chk("en_drop", {20'd0, bus_if.cnt_o, bus_if.pwm_o}, {20'd0, 8'd0, 4'b0010});
    cyc();
    bus_if.en_i = 1'b1;
    cyc();
    chk("en_restart", {23'd0, bus_if.cnt_o, bus_if.sync_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc();

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_reset", {17'd0, bus_if.pwm_o, bus_if.cnt_o, 1'b0, bus_if.sync_o, bus_if.load_ack_o}, 32'd0);
    bus_if.en_i = 1'b0; bus_if.pol_i = 4'b1010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("post_reset_pol", 32'(bus_if.pwm_o), 32'h0000000A);

    for (int i = 0; i < 3000; i++) begin
      bus_if.en_i   = ($urandom_range(0, 31) != 0);
      bus_if.load_i = ($urandom_range(0, 15) == 0);
      bus_if.mode_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) bus_if.period_i = 8'($urandom_range(0, 255));
      else bus_if.period_i = 8'($urandom_range(0, 12));
      for (int k = 0; k < 4; k++) bus_if.duty_i[k*8 +: 8] = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 31) == 0) bus_if.pol_i = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
